instr_phase_ctrl: RTL and testbench

Multi-cycle instruction phase controller for the CN1 processor datapath. It sequences each instruction through five one-hot phases (FETCH, DECODE, EXEC, MEM, WB), stretches memory phases on a ready handshake, skips MEM for non-memory instructions, and stops cleanly on a halt request. It sits between the top-level run control and the datapath's register, ALU and memory enables, and replaces free-running phase counting with handshake-aware sequencing.

---
 rtl/cn1_ctrl_pkg.sv | 17 +
 rtl/retire_counter.sv | 35 +++
 rtl/instr_phase_ctrl.sv | 117 +++++++++++
 tb/tb_instr_phase_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cn1_ctrl_pkg.sv
// Shared CN1 control definitions.
// The phase encoding is one-hot, and IDLE is the all-zero value. Datapath decoders use the
// same constants to derive their register, ALU and memory enables.
package cn1_ctrl_pkg;

  localparam int unsigned PHASE_W = 5;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE   = 5'b00000,
    PH_FETCH  = 5'b00001,
    PH_DECODE = 5'b00010,
    PH_EXEC   = 5'b00100,
    PH_MEM    = 5'b01000,
    PH_WB     = 5'b10000
  } phase_e;

endpackage

// File: rtl/retire_counter.sv
// Wrap-around counter of retired instructions.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset; clears the count
//   en    - increment enable, one per retirement
//   count - current count, wraps modulo 2^Width
module retire_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_phase_ctrl.sv
// Multi-cycle instruction phase controller for the CN1 datapath.
// Each instruction moves through these one-hot phases: FETCH, DECODE, EXEC, optional MEM, then WB.
// The FETCH and MEM phases stretch until the memory handshake completes. A halt request takes
// effect once the current instruction retires.
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous, active-low reset
//   start       - begin execution; honoured only in IDLE
//   halt        - stop after the current instruction retires
//   mem_ready   - memory handshake; completes FETCH and MEM
//   is_mem_op   - decode result, sampled on the last cycle of DECODE
//   cycle       - one-hot phase (00000 in IDLE)
//   busy        - high whenever cycle is not IDLE
//   mem_req     - memory request in FETCH and MEM
//   stall       - memory request not yet acknowledged
//   pc_inc      - single pulse per completed fetch
//   wb_en       - register write-back enable
//   instr_count - retired instructions, wrapping
module instr_phase_ctrl
  import cn1_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INSTR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   mem_ready,
  input  logic                   is_mem_op,
  output logic [PHASE_W-1:0]     cycle,
  output logic                   busy,
  output logic                   mem_req,
  output logic                   stall,
  output logic                   pc_inc,
  output logic                   wb_en,
  output logic [NUM_INSTR_W-1:0] instr_count
);

  phase_e phase_q, phase_d;
  logic   halt_pending_q, halt_pending_d;
  logic   mem_op_q, mem_op_d;

  always_comb begin
    phase_d        = phase_q;
    halt_pending_d = halt_pending_q;
    mem_op_d       = mem_op_q;
    unique case (phase_q)
      PH_IDLE: begin
        // start has priority over halt in IDLE; a fresh run never carries a stale halt.
        halt_pending_d = 1'b0;
        if (start) begin
          phase_d = PH_FETCH;
        end
      end
      PH_FETCH: begin
        halt_pending_d = halt_pending_q | halt;
        if (mem_ready) begin
          phase_d = PH_DECODE;
        end
      end
      PH_DECODE: begin
        halt_pending_d = halt_pending_q | halt;
        mem_op_d       = is_mem_op;
        phase_d        = PH_EXEC;
      end
      PH_EXEC: begin
        halt_pending_d = halt_pending_q | halt;
        phase_d        = mem_op_q ? PH_MEM : PH_WB;
      end
      PH_MEM: begin
        halt_pending_d = halt_pending_q | halt;
        if (mem_ready) begin
          phase_d = PH_WB;
        end
      end
      PH_WB: begin
        // WB always exits, so the pending halt is consumed here.
        halt_pending_d = 1'b0;
        phase_d        = (halt_pending_q | halt) ? PH_IDLE : PH_FETCH;
      end
      default: begin
        // A corrupted (non-one-hot) phase recovers to IDLE.
        halt_pending_d = 1'b0;
        phase_d        = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q        <= PH_IDLE;
      halt_pending_q <= 1'b0;
      mem_op_q       <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      halt_pending_q <= halt_pending_d;
      mem_op_q       <= mem_op_d;
    end
  end

  assign cycle   = phase_q;
  assign busy    = (phase_q != PH_IDLE);
  assign mem_req = (phase_q == PH_FETCH) | (phase_q == PH_MEM);
  assign stall   = mem_req & ~mem_ready;
  assign pc_inc  = (phase_q == PH_FETCH) & mem_ready;
  assign wb_en   = (phase_q == PH_WB);

  retire_counter #(
    .Width(NUM_INSTR_W)
  ) u_retire_counter (
    .clk  (clk),
    .reset(reset),
    .en   (wb_en),
    .count(instr_count)
  );

endmodule

// File: tb/tb_instr_phase_ctrl.sv
module tb_instr_phase_ctrl;

  localparam int unsigned W = 2;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] FET  = 5'b00001;
  localparam logic [4:0] DEC  = 5'b00010;
  localparam logic [4:0] EXE  = 5'b00100;
  localparam logic [4:0] MEM  = 5'b01000;
  localparam logic [4:0] WB   = 5'b10000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         halt;
  logic         mem_ready;
  logic         is_mem_op;
  logic [4:0]   cycle;
  logic         busy;
  logic         mem_req;
  logic         stall;
  logic         pc_inc;
  logic         wb_en;
  logic [W-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_phase_ctrl #(
    .NUM_INSTR_W(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .mem_ready  (mem_ready),
    .is_mem_op  (is_mem_op),
    .cycle      (cycle),
    .busy       (busy),
    .mem_req    (mem_req),
    .stall      (stall),
    .pc_inc     (pc_inc),
    .wb_en      (wb_en),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled well before the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    halt      = 1'b0;
    mem_ready = 1'b1;
    is_mem_op = 1'b1;
    #3;
    check("rst_cycle", 32'(cycle), 32'(IDLE));
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_pc_inc", 32'(pc_inc), 0);
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_count", 32'(instr_count), 0);
    #9;
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(cycle), 32'(IDLE));

    // Memory instruction, always ready.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("m_fetch", 32'(cycle), 32'(FET));
    check("m_fetch_pc_inc", 32'(pc_inc), 1);
    check("m_fetch_req", 32'(mem_req), 1);
    check("m_fetch_busy", 32'(busy), 1);
    tick();
    check("m_decode", 32'(cycle), 32'(DEC));
    check("m_decode_pc_inc", 32'(pc_inc), 0);
    tick();
    check("m_exec", 32'(cycle), 32'(EXE));
    tick();
    check("m_mem", 32'(cycle), 32'(MEM));
    check("m_mem_req", 32'(mem_req), 1);
    tick();
    check("m_wb", 32'(cycle), 32'(WB));
    check("m_wb_en", 32'(wb_en), 1);
    check("m_wb_count", 32'(instr_count), 0);
    tick();
    check("m_refetch", 32'(cycle), 32'(FET));
    check("m_count", 32'(instr_count), 1);

    // Non-memory instruction: EXEC goes straight to WB.
    is_mem_op = 1'b0;
    tick();
    check("n_decode", 32'(cycle), 32'(DEC));
    check("n_decode_req", 32'(mem_req), 0);
    tick();
    check("n_exec", 32'(cycle), 32'(EXE));
    check("n_exec_req", 32'(mem_req), 0);
    tick();
    check("n_wb", 32'(cycle), 32'(WB));
    check("n_wb_req", 32'(mem_req), 0);
    tick();
    check("n_refetch", 32'(cycle), 32'(FET));
    check("n_count", 32'(instr_count), 2);

    // FETCH stalled for 3 cycles, then a MEM stall, then halt during WB.
    mem_ready = 1'b0;
    is_mem_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fs_cycle", 32'(cycle), 32'(FET));
      check("fs_stall", 32'(stall), 1);
      check("fs_pc_inc", 32'(pc_inc), 0);
      if (i != 2) tick();
    end
    mem_ready = 1'b1;
    #1;
    check("fs_release_pc_inc", 32'(pc_inc), 1);
    check("fs_release_stall", 32'(stall), 0);
    tick();
    check("fs_decode", 32'(cycle), 32'(DEC));
    check("fs_decode_pc_inc", 32'(pc_inc), 0);
    tick();
    tick();
    check("ms_mem", 32'(cycle), 32'(MEM));
    mem_ready = 1'b0;
    #1;
    check("ms_stall", 32'(stall), 1);
    tick();
    check("ms_hold", 32'(cycle), 32'(MEM));
    mem_ready = 1'b1;
    tick();
    check("hw_wb", 32'(cycle), 32'(WB));
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("hw_idle", 32'(cycle), 32'(IDLE));
    check("hw_busy", 32'(busy), 0);
    check("hw_count", 32'(instr_count), 3);

    // Halt pulse during EXEC of a non-memory instruction; counter wraps 3 -> 0.
    is_mem_op = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("he_exec", 32'(cycle), 32'(EXE));
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("he_wb", 32'(cycle), 32'(WB));
    tick();
    check("he_idle", 32'(cycle), 32'(IDLE));
    check("he_busy", 32'(busy), 0);
    check("he_count_wrap", 32'(instr_count), 0);
    tick();
    check("he_idle_stays", 32'(cycle), 32'(IDLE));

    // start and halt together in IDLE: the run starts and the halt is dropped.
    start = 1'b1;
    halt  = 1'b1;
    tick();
    start = 1'b0;
    halt  = 1'b0;
    check("sh_fetch", 32'(cycle), 32'(FET));
    tick();
    tick();
    tick();
    check("sh_wb", 32'(cycle), 32'(WB));
    tick();
    check("sh_continues", 32'(cycle), 32'(FET));
    check("sh_count", 32'(instr_count), 1);

    // start held through WB while a halt is pending: IDLE for a cycle, then FETCH.
    start = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    check("sp_wb", 32'(cycle), 32'(WB));
    tick();
    check("sp_idle", 32'(cycle), 32'(IDLE));
    check("sp_count", 32'(instr_count), 2);
    tick();
    start = 1'b0;
    check("sp_restart", 32'(cycle), 32'(FET));

    // Reset asserted mid-MEM takes effect immediately.
    is_mem_op = 1'b1;
    tick();
    tick();
    tick();
    check("rm_mem", 32'(cycle), 32'(MEM));
    mem_ready = 1'b0;
    reset     = 1'b0;
    #1;
    check("rm_cycle", 32'(cycle), 32'(IDLE));
    check("rm_busy", 32'(busy), 0);
    check("rm_mem_req", 32'(mem_req), 0);
    check("rm_stall", 32'(stall), 0);
    check("rm_count", 32'(instr_count), 0);
    tick();
    reset     = 1'b1;
    mem_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("rm_restart", 32'(cycle), 32'(FET));

    // Five instructions with alternating MEM: expected count 1,2,3,0,1.
    for (int n = 1; n <= 5; n++) begin
      is_mem_op = n[0];
      tick();
      tick();
      if (n[0]) begin
        tick();
        check("seq_mem", 32'(cycle), 32'(MEM));
      end
      tick();
      check("seq_wb", 32'(cycle), 32'(WB));
      tick();
      check("seq_count", 32'(instr_count), 32'(n % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
